// File: rtl/master_arbiter.sv
// Two-master, one-slave round-robin arbiter. The granted master's request
// bus is forwarded combinationally to the slave, and the slave's response goes back to that master.
module master_arbiter #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         master_1_req,
    input  logic [N-1:0] master_1_addr,
    input  logic         master_1_cmd,
    input  logic [N-1:0] master_1_wdata,
    output logic         master_1_ack,
    output logic [N-1:0] master_1_rdata,

    input  logic         master_2_req,
    input  logic [N-1:0] master_2_addr,
    input  logic         master_2_cmd,
    input  logic [N-1:0] master_2_wdata,
    output logic         master_2_ack,
    output logic [N-1:0] master_2_rdata,

    output logic         slave_req,
    output logic [N-1:0] slave_addr,
    output logic         slave_cmd,
    output logic [N-1:0] slave_wdata,
    input  logic         slave_ack,
    input  logic [N-1:0] slave_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_1 = 2'd1,
        GRANT_2 = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last_grant;

    // Grant sequencing; last_grant only moves on a completed transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 2'd2;
        end else begin
            case (state)
                IDLE: begin
                    if (master_1_req && master_2_req) begin
                        state <= (last_grant == 2'd1) ? GRANT_2 : GRANT_1;
                    end else if (master_1_req) begin
                        state <= GRANT_1;
                    end else if (master_2_req) begin
                        state <= GRANT_2;
                    end
                end
                GRANT_1: begin
                    if (!master_1_req) begin
                        state <= IDLE;
                    end else if (slave_ack) begin
                        last_grant <= 2'd1;
                        state      <= master_2_req ? GRANT_2 : IDLE;
                    end
                end
                GRANT_2: begin
                    if (!master_2_req) begin
                        state <= IDLE;
                    end else if (slave_ack) begin
                        last_grant <= 2'd2;
                        state      <= master_1_req ? GRANT_1 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus steering. An ack only counts while the granted master is still requesting,
    // because a transfer completes only with slave_req high.
    always_comb begin
        slave_req      = 1'b0;
        slave_addr     = '0;
        slave_cmd      = 1'b0;
        slave_wdata    = '0;
        master_1_ack   = 1'b0;
        master_1_rdata = '0;
        master_2_ack   = 1'b0;
        master_2_rdata = '0;
        case (state)
            GRANT_1: begin
                slave_req      = master_1_req;
                slave_addr     = master_1_addr;
                slave_cmd      = master_1_cmd;
                slave_wdata    = master_1_wdata;
                master_1_ack   = slave_ack & master_1_req;
                master_1_rdata = slave_rdata;
            end
            GRANT_2: begin
                slave_req      = master_2_req;
                slave_addr     = master_2_addr;
                slave_cmd      = master_2_cmd;
                slave_wdata    = master_2_wdata;
                master_2_ack   = slave_ack & master_2_req;
                master_2_rdata = slave_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_master_arbiter.sv
// Bench for master_arbiter: directed vector table, hand-written reset and
// abandon sequences, and a randomized run checked against a transaction-level model.
module tb_master_arbiter;
    localparam int unsigned N = 32;
    localparam logic [N-1:0] A1 = 32'h0000_0010;
    localparam logic [N-1:0] A2 = 32'h0000_0020;
    localparam logic [N-1:0] W1 = 32'h1234_5678;
    localparam logic [N-1:0] W2 = 32'hFFFF_FFFF;
    localparam logic [N-1:0] RD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         master_1_req, master_1_cmd, master_1_ack;
    logic [N-1:0] master_1_addr, master_1_wdata, master_1_rdata;
    logic         master_2_req, master_2_cmd, master_2_ack;
    logic [N-1:0] master_2_addr, master_2_wdata, master_2_rdata;
    logic         slave_req, slave_cmd, slave_ack;
    logic [N-1:0] slave_addr, slave_wdata, slave_rdata;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    master_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .master_1_req(master_1_req), .master_1_addr(master_1_addr),
        .master_1_cmd(master_1_cmd), .master_1_wdata(master_1_wdata),
        .master_1_ack(master_1_ack), .master_1_rdata(master_1_rdata),
        .master_2_req(master_2_req), .master_2_addr(master_2_addr),
        .master_2_cmd(master_2_cmd), .master_2_wdata(master_2_wdata),
        .master_2_ack(master_2_ack), .master_2_rdata(master_2_rdata),
        .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
        .slave_wdata(slave_wdata), .slave_ack(slave_ack), .slave_rdata(slave_rdata)
    );

    typedef struct {
        logic       rst;
        logic       r1;
        logic       r2;
        logic       sack;
        logic       e_sreq;
        logic [1:0] e_fwd;   // whose addr/cmd/wdata should be on the slave bus (0 = none)
        logic       e_ack1;
        logic       e_ack2;
        logic [1:0] e_rd;    // which master should see slave_rdata (0 = none)
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rs, input logic r1, input logic r2, input logic sa,
                                input logic sq, input logic [1:0] fw, input logic a1,
                                input logic a2, input logic [1:0] rd);
        vec_t v;
        v.rst = rs; v.r1 = r1; v.r2 = r2; v.sack = sa; v.e_sreq = sq;
        v.e_fwd = fw; v.e_ack1 = a1; v.e_ack2 = a2; v.e_rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic e_sreq, input logic [N-1:0] e_addr,
                         input logic e_cmd, input logic [N-1:0] e_wdata, input logic e_ack1,
                         input logic e_ack2, input logic [N-1:0] e_rd1, input logic [N-1:0] e_rd2);
        logic [4*N+3:0] got, exp;
        got = {slave_req, slave_addr, slave_cmd, slave_wdata,
               master_1_ack, master_2_ack, master_1_rdata, master_2_rdata};
        exp = {e_sreq, e_addr, e_cmd, e_wdata, e_ack1, e_ack2, e_rd1, e_rd2};
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got {sreq,addr,cmd,wdata,ack1,ack2,rd1,rd2}=%h required %h",
                      name, got, exp);
    endtask

    task automatic check_fwd(input string name, input logic sreq, input logic [1:0] fw,
                             input logic a1, input logic a2, input logic [1:0] rd);
        check(name, sreq,
              (fw == 2'd1) ? A1 : (fw == 2'd2) ? A2 : '0,
              (fw == 2'd2),
              (fw == 2'd1) ? W1 : (fw == 2'd2) ? W2 : '0,
              a1, a2,
              (rd == 2'd1) ? RD : '0,
              (rd == 2'd2) ? RD : '0);
    endtask

    task automatic set_fixed_bus();
        master_1_addr = A1; master_1_wdata = W1; master_1_cmd = 1'b0;
        master_2_addr = A2; master_2_wdata = W2; master_2_cmd = 1'b1;
        slave_rdata = RD;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: who owns the slave and who finished last.
    int owner;
    int last;

    initial begin
        logic r1, r2, sa, rs;
        logic ack1_prev, ack2_prev;
        logic e_sreq, e_cmd, e_a1, e_a2;
        logic [N-1:0] e_addr, e_wd, e_rd1, e_rd2;

        rst = 1'b0;
        master_1_req = 1'b0; master_2_req = 1'b0; slave_ack = 1'b0;
        set_fixed_bus();
        #1;
        check_fwd("reset_outputs_zero", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        master_1_req = 1'b1; master_2_req = 1'b1; slave_ack = 1'b1;
        #1;
        check_fwd("reset_ignores_inputs", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        master_1_req = 1'b0; master_2_req = 1'b0; slave_ack = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // rst, r1, r2, sack | sreq, fwd, ack1, ack2, rd
        vecs.push_back(mk(1,1,0,0, 0,0,0,0,0));  // single master request seen in IDLE
        vecs.push_back(mk(1,1,0,1, 1,1,1,0,1));  // 1st grant cycle completes read
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0));  // back to IDLE
        vecs.push_back(mk(0,1,1,0, 0,0,0,0,0));  // reset: tie goes to master 1 afterwards
        vecs.push_back(mk(1,1,1,0, 0,0,0,0,0));  // tie sampled in IDLE
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,1,1,0, 1,1,0,0,1));  // stalled slave, master 2 waits
        vecs.push_back(mk(1,1,1,1, 1,1,1,0,1));  // transfer 1 (master 1)
        vecs.push_back(mk(1,1,1,0, 1,2,0,0,2));  // master 2 write on bus, no idle gap
        vecs.push_back(mk(1,1,1,1, 1,2,0,1,2));  // transfer 2 (master 2)
        for (int i = 0; i < 6; i++)               // transfers 3..8 alternate
            vecs.push_back(mk(1,1,1,1, 1,(i % 2 == 0) ? 2'd1 : 2'd2,
                              (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? 2'd1 : 2'd2));
        vecs.push_back(mk(1,0,1,0, 0,1,0,0,1));  // master 1 abandons in GRANT_1
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0));  // spurious ack in IDLE ignored
        vecs.push_back(mk(1,1,1,0, 0,0,0,0,0));  // tie: last_grant still 2
        vecs.push_back(mk(1,1,1,0, 1,1,0,0,1));  // master 1 wins

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            master_1_req = vecs[i].r1; master_2_req = vecs[i].r2; slave_ack = vecs[i].sack;
            #1;
            check_fwd($sformatf("vec%0d", i), vecs[i].e_sreq, vecs[i].e_fwd,
                      vecs[i].e_ack1, vecs[i].e_ack2, vecs[i].e_rd);
            next_cycle();
        end

        // Reset mid-transfer while master 2 owns the slave.
        master_1_req = 1'b0; master_2_req = 1'b0; slave_ack = 1'b0;
        next_cycle();                                  // GRANT_1 abandoned -> IDLE
        master_2_req = 1'b1;
        next_cycle();                                  // IDLE -> GRANT_2
        #1;
        check_fwd("g2_before_reset", 1'b1, 2'd2, 1'b0, 1'b0, 2'd2);
        #1;
        rst = 1'b0; slave_ack = 1'b1;
        #1;
        check_fwd("async_reset_drops_req", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        next_cycle();
        rst = 1'b1; slave_ack = 1'b0; master_1_req = 1'b1; master_2_req = 1'b1;
        #1;
        check_fwd("post_reset_idle", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        next_cycle();
        #1;
        check_fwd("post_reset_tie_m1", 1'b1, 2'd1, 1'b0, 1'b0, 2'd1);

        // Randomized phase against the reference model.
        master_1_req = 1'b0; master_2_req = 1'b0; slave_ack = 1'b0;
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        owner = 0; last = 2;
        ack1_prev = 1'b0; ack2_prev = 1'b0;
        r1 = 1'b0; r2 = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Masters normally hold req until ack; occasionally they abandon.
            if (ack1_prev || !r1) r1 = ($urandom_range(0, 2) == 0);
            else r1 = ($urandom_range(0, 31) != 0);
            if (ack2_prev || !r2) r2 = ($urandom_range(0, 2) == 0);
            else r2 = ($urandom_range(0, 31) != 0);
            sa = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 199) != 0);
            rst = rs;
            master_1_req = r1; master_2_req = r2; slave_ack = sa;
            master_1_addr = $urandom; master_1_wdata = $urandom; master_1_cmd = 1'($urandom);
            master_2_addr = $urandom; master_2_wdata = $urandom; master_2_cmd = 1'($urandom);
            slave_rdata = $urandom;
            #1;
            if (!rs) owner = 0;
            e_sreq = 1'b0; e_addr = '0; e_cmd = 1'b0; e_wd = '0;
            e_a1 = 1'b0; e_a2 = 1'b0; e_rd1 = '0; e_rd2 = '0;
            if (owner == 1) begin
                e_sreq = r1; e_addr = master_1_addr; e_cmd = master_1_cmd; e_wd = master_1_wdata;
                e_a1 = r1 & sa; e_rd1 = slave_rdata;
            end else if (owner == 2) begin
                e_sreq = r2; e_addr = master_2_addr; e_cmd = master_2_cmd; e_wd = master_2_wdata;
                e_a2 = r2 & sa; e_rd2 = slave_rdata;
            end
            check($sformatf("rand%0d", cyc), e_sreq, e_addr, e_cmd, e_wd, e_a1, e_a2, e_rd1, e_rd2);

            if (!rs) begin
                owner = 0; last = 2;
            end else if (owner == 0) begin
                if (r1 && r2) owner = 3 - last;
                else if (r1) owner = 1;
                else if (r2) owner = 2;
            end else if (!(owner == 1 ? r1 : r2)) begin
                owner = 0;
            end else if (sa) begin
                last = owner;
                owner = ((owner == 1) ? r2 : r1) ? 3 - owner : 0;
            end
            ack1_prev = e_a1; ack2_prev = e_a2;
            next_cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/master_arbiter.md
MASTER_ARBITER -- requirements
Module: master_arbiter

Interface
REQ-001 Parameter N, default 32, width of addr, wdata and rdata buses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 master_1_req  input  1  master 1 transaction request, held until master_1_ack.
REQ-005 master_1_addr  input  N  master 1 address.
REQ-006 master_1_cmd  input  1  master 1 command: 0 = read, 1 = write.
REQ-007 master_1_wdata  input  N  master 1 write data.
REQ-008 master_1_ack  output  1  master 1 completion strobe.
REQ-009 master_1_rdata  output  N  master 1 read data, valid with master_1_ack.
REQ-010 master_2_req, master_2_addr, master_2_cmd, master_2_wdata, master_2_ack, master_2_rdata SHALL mirror REQ-004..REQ-009 for master 2.
REQ-011 slave_req  output  1  request to the shared slave.
REQ-012 slave_addr, slave_cmd, slave_wdata  output  N/1/N  forwarded from the granted master.
REQ-013 slave_ack  input  1  slave completion; transfer completes in a cycle with slave_req=1 and slave_ack=1.
REQ-014 slave_rdata  input  N  slave read data, valid with slave_ack.

Function
REQ-015 The FSM SHALL have three states: IDLE, GRANT_1, GRANT_2, held in a registered state variable.
REQ-016 A registered pointer last_grant (1 or 2) SHALL record the master most recently completed.
REQ-017 IDLE: slave_req=0, slave_addr/cmd/wdata=0, both master acks=0, both master rdata=0.
REQ-018 IDLE -> GRANT_1 if only master_1_req=1; -> GRANT_2 if only master_2_req=1; both requesting -> grant the master not equal to last_grant.
REQ-019 Minimum arbitration latency: request sampled in IDLE -> slave_req asserted the following cycle.
REQ-020 GRANT_x: slave_req, slave_addr, slave_cmd, slave_wdata SHALL combinationally equal master_x's signals.
REQ-021 GRANT_x: master_x_ack = slave_ack and master_x_rdata = slave_rdata (combinational); the other master's ack=0, rdata=0.
REQ-022 GRANT_x with slave_ack=1: last_grant <= x; next state = GRANT of the other master if it requests this cycle, else IDLE.
REQ-023 GRANT_x with slave_ack=0 and master_x_req=1: remain in GRANT_x, no timeout.
REQ-024 GRANT_x with master_x_req=0 (abandoned request): next state IDLE, no ack, last_grant unchanged.
REQ-025 A non-granted master's request SHALL never reach the slave; its ack SHALL stay 0 until granted.
REQ-026 Write transfers: master_x_rdata SHALL still follow slave_rdata during ack; masters ignore it.
REQ-027 Fairness: with both masters continuously requesting, grants SHALL alternate 1,2,1,2 with no idle cycle between completions.
REQ-028 slave_ack while in IDLE SHALL be ignored: no state change, no master ack.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE and last_grant=2, so master 1 wins the first tie.
REQ-030 During reset all outputs SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL abort it: slave_req drops asynchronously and no ack is produced.
REQ-032 After rst returns to 1, arbitration SHALL resume from IDLE on the next rising edge.

Verification
REQ-033 Single master: master_1 read addr=32'h0000_0010, slave_ack on the 1st grant cycle with rdata=32'hDEAD_BEEF -> master_1_ack pulses 1 cycle with rdata=32'hDEAD_BEEF; FSM returns to IDLE.
REQ-034 Tie after reset: both req=1 -> GRANT_1 first; on its ack -> GRANT_2 the next cycle; master_2 write wdata=32'hFFFF_FFFF appears on slave_wdata.
REQ-035 Stalled slave: slave_ack=0 for 5 cycles while master_2 waits -> slave signals stay equal to master_1's; master_2_ack=0; on slave_ack=1, grant passes to master 2.
REQ-036 Continuous contention over 8 transfers -> grant order 1,2,1,2,1,2,1,2; no IDLE cycles between transfers.
REQ-037 Reset mid-transfer: rst=0 while in GRANT_2 -> slave_req=0 immediately; after release, both req=1 -> master 1 granted.
REQ-038 Abandon and spurious ack: master_1 drops req in GRANT_1 -> IDLE, no ack; slave_ack=1 in IDLE -> both master acks remain 0.
